uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter: accepts a parallel byte over a valid/ready handshake and shifts it out on tx.
//  Frame is start(0), DATA_BITS LSB-first, optional parity, STOP_BITS stop(1).
//  Transmit-side counterpart of uart_rx, with the same clocking and bit timing.
//  Defaults give 100 MHz clk at 9600 baud, so tx can loop back directly into uart_rx.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per serial bit (>=2)
//  DATA_BITS     8      data bits per frame (5..8)
//  PARITY_EN     0      1 = insert parity bit after data
//  PARITY_ODD    0      0 = even parity, 1 = odd (ignored if PARITY_EN=0)
//  STOP_BITS     1      stop bits per frame (1 or 2)
// PORTS
//  clk       in   1          system clock, all logic on rising edge
//  rst       in   1          asynchronous, active-high reset
//  tx_data   in   DATA_BITS  byte to send, sampled only on handshake
//  tx_start  in   1          request/valid
//  tx_ready  out  1          1 = idle, will accept tx_start this cycle
//  tx        out  1          serial line, idle high, registered
//  tx_busy   out  1          1 while a frame is on the line
//  tx_done   out  1          1-cycle pulse in last cycle of final stop bit
// BEHAVIOUR
//  - Reset (async): state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, tx_ready=1; applies immediately, mid-frame included.
//  - States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  - tx_ready = (state==IDLE). Handshake = tx_start & tx_ready.
//    On handshake: latch tx_data into shift reg, compute parity, enter START.
//  - Latency: tx falls on the first clk edge after the handshake edge (registered output).
//  - Bit timer counts 0..CLKS_PER_BIT-1; each bit holds tx stable for exactly CLKS_PER_BIT cycles.
//    The timer clears on every bit transition.
//  - DATA: bit index 0..DATA_BITS-1, shift right, tx = shreg[0].
//  - Parity: even = ^data; odd = ~^data; computed from the latched value.
//  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in its final cycle; next cycle state=IDLE.
//  - Back-to-back: tx_start held high starts the next frame in the first IDLE cycle.
//    Exactly 1 idle-high cycle separates frames; frame period = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS)+1.
//  - tx_start while busy is ignored, not queued. tx_data changes after the handshake have no effect.
//  - tx_busy = ~tx_ready. No X on tx at any time after reset.
//  - Counter widths are $clog2 of their maximum value; no wrap beyond terminal count.
// STRUCTURE
//  - Shared include uart_defs.vh: state encodings, DEFAULT_CLKS_PER_BIT=10416 (100 MHz / 9600).
//    uart_rx uses the same constant.
//  - One sub-module, uart_bit_timer: clear input, terminal-count tick output, parameter CLKS_PER_BIT.
//    It is reusable by uart_rx.
//  - FSM, shift register, bit counter and parity reg live in uart_tx.
// TESTING (clk period 10 ns; tx looped back to uart_rx where noted)
//  1. Single byte: tx_start 1 cycle, tx_data=0x55
//     -> tx low for exactly 10416 cycles; then bits 1,0,1,0,1,0,1,0 at 10416 cycles each; stop high 10416.
//     -> tx_done pulses once, 104160 cycles after the first low; uart_rx reports rx_data=0x55.
//  2. Back-to-back: send 0x55 then 0xA3 with tx_start held high
//     -> second start bit begins 1 cycle after the first tx_done; uart_rx yields 0x55 then 0xA3.
//  3. Busy ignore: mid-frame of 0x3C, pulse tx_start with tx_data=0xFF and also change tx_data
//     -> line carries 0x3C only; exactly one tx_done; no second frame.
//  4. Reset mid-frame: assert rst during data bit 3 of 0x00
//     -> tx=1 and tx_ready=1 without waiting for a clk edge.
//     -> after release, tx_start with 0x81 produces a clean frame; uart_rx gets 0x81.
//  5. Parity/stop: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte 0xA3
//     -> parity bit 0 (four ones); stop held 20832 cycles.
//     -> with PARITY_ODD=1 the parity bit is 1.
//  6. Fast timing: CLKS_PER_BIT=4, DATA_BITS=8, tx_start held for 3 frames
//     -> each frame 40 cycles low/data/stop, period 41, three tx_done pulses 41 cycles apart.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encoding and default bit timing shared by the UART blocks.
package uart_tx_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with terminal-count tick and clear.
module uart_bit_timer import uart_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, start/data/parity/stop frame out on a registered tx line.
module uart_tx import uart_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    state_t state, state_n;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic par, tick, tx_n, last;
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk), .rst(rst), .clr(tx_ready), .tick(tick)
    );
    assign tx_ready = state == IDLE;
    assign tx_busy  = ~tx_ready;
    assign last     = bit_cnt == (state == STOP ? LAST_STOP : LAST_DATA);
    assign tx_done  = state == STOP && tick && last;
    // tx_n is the level of the bit being entered, so tx lines up with state
    always_comb begin
        state_n = state;
        tx_n = tx;
        case (state)
            IDLE:   if (tx_start) begin state_n = START; tx_n = 1'b0; end
            START:  if (tick) begin state_n = DATA; tx_n = shreg[0]; end
            DATA:   if (tick) begin
                if (!last) tx_n = shreg[1];
                else if (PARITY_EN != 0) begin state_n = PARITY; tx_n = par; end
                else begin state_n = STOP; tx_n = 1'b1; end
            end
            PARITY: if (tick) begin state_n = STOP; tx_n = 1'b1; end
            STOP:   if (tick && last) state_n = IDLE;
            default: begin state_n = IDLE; tx_n = 1'b1; end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            shreg <= '0;
            bit_cnt <= '0;
            par <= 1'b0;
        end else begin
            state <= state_n;
            tx <= tx_n;
            if (tx_ready && tx_start) begin
                shreg <= tx_data;
                par <= ^tx_data ^ (PARITY_ODD != 0);
            end else if (state == DATA && tick) shreg <= shreg >> 1;
            if (tick) bit_cnt <= (state_n != state) ? '0 : bit_cnt + 1'b1;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations checked each cycle against a frame-level model.
module tb_uart_tx;
    logic clk = 1'b0, rst = 1'b1, tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [2:0] tx_v, rdy_v, bsy_v, dn_v;
    int checks = 0, errors = 0;
    int cpb [3] = '{4, 3, 2};
    int db  [3] = '{8, 8, 5};
    int pe  [3] = '{0, 1, 1};
    int po  [3] = '{0, 0, 1};
    int sb  [3] = '{1, 2, 1};
    bit mb [3];
    int mp [3], ml [3];
    bit mf [3][12];

    uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(bsy_v[0]), .tx_done(dn_v[0]));
    uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(bsy_v[1]), .tx_done(dn_v[1]));
    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .tx_data(tx_data[4:0]), .tx_start(tx_start),
        .tx_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(bsy_v[2]), .tx_done(dn_v[2]));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // frame model: a list of bit levels, each held cpb cycles, then one idle cycle
    initial begin
        int n;
        bit p;
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 3; i++) begin
                if (rst) mb[i] = 1'b0;
                else if (mb[i]) begin
                    mp[i]++;
                    if (mp[i] == ml[i]) mb[i] = 1'b0;
                end else if (tx_start) begin
                    p = po[i] != 0;
                    mf[i][0] = 1'b0;
                    for (int j = 0; j < db[i]; j++) begin
                        mf[i][j + 1] = tx_data[j];
                        p ^= tx_data[j];
                    end
                    n = db[i] + 1;
                    if (pe[i] != 0) begin mf[i][n] = p; n++; end
                    for (int s = 0; s < sb[i]; s++) begin mf[i][n] = 1'b1; n++; end
                    ml[i] = n * cpb[i];
                    mp[i] = 0;
                    mb[i] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tx[%0d]", i), tx_v[i], mb[i] ? mf[i][mp[i] / cpb[i]] : 1'b1);
            check($sformatf("ready[%0d]", i), rdy_v[i], !mb[i]);
            check($sformatf("busy[%0d]", i), bsy_v[i], mb[i]);
            check($sformatf("done[%0d]", i), dn_v[i], mb[i] && mp[i] == ml[i] - 1);
        end
    end

    initial begin
        logic [39:0] ca, cd, cb, cc;
        logic [9:0] ma;
        logic [11:0] mbv;
        logic [7:0] mc;
        int dt [4];
        int nd, db_i, dc_i;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_v, 3'b111);
        check("reset_ready", rdy_v, 3'b111);
        check("reset_busy", bsy_v, 3'b000);
        check("reset_done", dn_v, 3'b000);

        pulse(8'h55);
        for (int k = 0; k < 40; k++) begin
            ca[k] = tx_v[0];
            cd[k] = dn_v[0];
            @(negedge clk);
        end
        check("single_line", ca, 40'hF0F0F0F0F0);
        check("single_done", cd, 40'h8000000000);
        check("single_idle", rdy_v[0], 1'b1);
        repeat (40) @(negedge clk);

        nd = 0;
        dt = '{-1, -1, -1, -1};
        for (int j = 0; j < 140; j++) begin
            @(negedge clk);
            if (dn_v[0]) begin
                if (nd < 4) dt[nd] = j;
                nd++;
            end
            if (j == 0) begin tx_data = 8'h55; tx_start = 1'b1; end
            if (j == 20) tx_data = 8'hA3;
            if (j == 60) tx_data = 8'h3C;
            if (j == 100) tx_start = 1'b0;
        end
        check("b2b_count", nd, 3);
        check("b2b_first", dt[0], 40);
        check("b2b_gap1", dt[1] - dt[0], 41);
        check("b2b_gap2", dt[2] - dt[1], 41);
        repeat (40) @(negedge clk);

        pulse(8'h3C);
        nd = 0;
        for (int j = 0; j < 60; j++) begin
            if (dn_v[0]) nd++;
            if (j == 15) begin tx_data = 8'hFF; tx_start = 1'b1; end
            if (j == 16) tx_start = 1'b0;
            if (j == 25) tx_data = 8'h12;
            @(negedge clk);
        end
        check("busy_ignore_done", nd, 1);
        check("busy_ignore_idle", rdy_v[0], 1'b1);
        repeat (40) @(negedge clk);

        pulse(8'h00);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", tx_v, 3'b111);
        check("async_rst_ready", rdy_v, 3'b111);
        check("async_rst_busy", bsy_v, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse(8'h81);
        for (int k = 0; k < 40; k++) begin
            ca[k] = tx_v[0];
            @(negedge clk);
        end
        check("post_rst_line", ca, 40'hFF000000F0);
        repeat (40) @(negedge clk);

        pulse(8'hA3);
        db_i = -1;
        dc_i = -1;
        for (int k = 0; k < 40; k++) begin
            ca[k] = tx_v[0];
            cb[k] = tx_v[1];
            cc[k] = tx_v[2];
            if (dn_v[1]) db_i = k;
            if (dn_v[2]) dc_i = k;
            @(negedge clk);
        end
        for (int n = 0; n < 10; n++) ma[n] = ca[4 * n + 1];
        for (int n = 0; n < 12; n++) mbv[n] = cb[3 * n + 1];
        for (int n = 0; n < 8; n++) mc[n] = cc[2 * n + 1];
        check("plain_a3_bits", ma, 10'h346);
        check("even_par_2stop_bits", mbv, 12'hD46);
        check("odd_par_5bit_bits", mc, 8'hC6);
        check("even_par_2stop_done", db_i, 35);
        check("odd_par_5bit_done", dc_i, 15);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
